// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader.
//   state_t        : loader sequencing states (FETCH, WRITE, DONE, ERROR)
//   BYTES_PER_WORD : number of ROM bytes packed into one RAM word
// Optional feature macro used by the loader: ROM_LOADER_CHECKSUM_EN
package rom_loader_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/rom_loader_packer.sv
// Byte-to-word packer for the boot ROM loader.
// Bytes arrive most-significant first. word_o always shows the word that
// would result if the byte currently on byte_i were the last one of the
// word: earlier bytes on the left, unused low bytes zero.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, clears lane count and bytes
//   sample_i   : byte_i is consumed at the next rising edge
//   flush_i    : together with sample_i, ends the current word (lanes restart)
//   byte_i     : incoming ROM byte
//   word_o     : left-aligned, zero-padded word including byte_i
//   lastLane_o : byte_i fills the final lane of the word
module rom_loader_packer
    import rom_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_i,
    input  logic        flush_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        lastLane_o
);

    // Only the three older bytes need storage; the fourth completes the word
    // and is forwarded straight to word_o.
    logic [23:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  laneNext;
    logic [31:0] shifted;

    always_comb begin
        shifted    = {word_q, byte_i};
        laneNext   = {1'b0, lane_q} + 3'd1;
        lastLane_o = (laneNext == 3'(BYTES_PER_WORD));

        // Left-align a partial word so its first byte lands in bits 31:24.
        case (laneNext)
            3'd1:    word_o = {shifted[7:0], 24'h000000};
            3'd2:    word_o = {shifted[15:0], 16'h0000};
            3'd3:    word_o = {shifted[23:0], 8'h00};
            default: word_o = shifted;
        endcase

        word_d = word_q;
        lane_d = lane_q;
        if (sample_i) begin
            if (flush_i) begin
                word_d = '0;
                lane_d = '0;
            end else begin
                word_d = shifted[23:0];
                lane_d = laneNext[1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot ROM loader: streams a byte image out of a ROM, packs it big-endian
// into 32-bit words and writes them to consecutive RAM word addresses,
// then raises boot_done (or boot_error if the byte limit runs out first).
// Parameters:
//   RAM_BASE  : RAM word address of the first word written
//   MAX_BYTES : byte limit before the image is declared overrun
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   rom_address             : registered ROM byte address
//   rom_byte, rom_done      : combinational ROM data / last-byte flag
//   ram_address, ram_data   : pending RAM write word address and data
//   ram_write, ram_ready    : write request / accept handshake
//   boot_done, boot_error   : sticky completion / overrun flags
//   checksum                : only with ROM_LOADER_CHECKSUM_EN, mod-256 sum
//                             of every sampled byte
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'd0,
    parameter logic [31:0] MAX_BYTES = 32'd65536
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    input  logic        ram_ready,
    output logic        boot_done,
    output logic        boot_error
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    state_t      state_q, state_d;
    logic [31:0] romAddress_q, romAddress_d;
    logic [31:0] ramAddress_q, ramAddress_d;
    logic [31:0] ramData_q, ramData_d;
    logic        ramWrite_q, ramWrite_d;
    logic [31:0] byteCount_q, byteCount_d;
    logic        lastWord_q, lastWord_d;
    logic        sample, flush, lastLane;
    logic [31:0] packedWord;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum_q, checksum_d;
`endif

    rom_loader_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .sample_i   (sample),
        .flush_i    (flush),
        .byte_i     (rom_byte),
        .word_o     (packedWord),
        .lastLane_o (lastLane)
    );

    // Next-state logic. The limit is checked before sampling, so a byte that
    // carries rom_done is always taken, even when it is the last byte the
    // limit allows; that word then finishes normally through WRITE -> DONE.
    // Bytes left in the packer when the limit trips are simply never written.
    always_comb begin
        state_d      = state_q;
        romAddress_d = romAddress_q;
        ramAddress_d = ramAddress_q;
        ramData_d    = ramData_q;
        ramWrite_d   = ramWrite_q;
        byteCount_d  = byteCount_q;
        lastWord_d   = lastWord_q;
        sample       = 1'b0;
        flush        = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        case (state_q)
            FETCH: begin
                if (byteCount_q >= MAX_BYTES) begin
                    state_d = ERROR;
                end else begin
                    sample       = 1'b1;
                    romAddress_d = romAddress_q + 32'd1;
                    byteCount_d  = byteCount_q + 32'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    checksum_d   = checksum_q + rom_byte;
`endif
                    if (lastLane || rom_done) begin
                        flush      = 1'b1;
                        ramData_d  = packedWord;
                        ramWrite_d = 1'b1;
                        lastWord_d = rom_done;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (ram_ready) begin
                    ramWrite_d   = 1'b0;
                    ramAddress_d = ramAddress_q + 32'd1;
                    state_d      = lastWord_q ? DONE : FETCH;
                end
            end
            default: begin
            end
        endcase
    end

    // State register; reset abandons any load in progress, including a
    // pending RAM write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            romAddress_q <= '0;
            ramAddress_q <= RAM_BASE;
            ramData_q    <= '0;
            ramWrite_q   <= 1'b0;
            byteCount_q  <= '0;
            lastWord_q   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            romAddress_q <= romAddress_d;
            ramAddress_q <= ramAddress_d;
            ramData_q    <= ramData_d;
            ramWrite_q   <= ramWrite_d;
            byteCount_q  <= byteCount_d;
            lastWord_q   <= lastWord_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign rom_address = romAddress_q;
    assign ram_address = ramAddress_q;
    assign ram_data    = ramData_q;
    assign ram_write   = ramWrite_q;
    assign boot_done   = (state_q == DONE);
    assign boot_error  = (state_q == ERROR);
`ifdef ROM_LOADER_CHECKSUM_EN
    assign checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader. Two instances share one clock:
// A (RAM_BASE=0, MAX_BYTES=302) for normal loads, and B (RAM_BASE=0x100,
// MAX_BYTES=8) for the overrun case. Expected RAM writes come from a model
// that places image bytes straight into word positions.
// Checksum checks are compiled in with ROM_LOADER_CHECKSUM_EN.
module tb_rom_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] MAX_A  = 32'd302;
    localparam logic [31:0] BASE_B = 32'h0000_0100;
    localparam logic [31:0] MAX_B  = 32'd8;
    localparam int          BUDGET = 3000;

    typedef struct {
        int len;
        bit hasDone;
        bit randomReady;
        int expWrites;
        bit expBootDone;
        int expCycles;
    } vector_t;

    typedef struct packed {
        logic [31:0] romAddress;
        logic [31:0] ramAddress;
        logic [31:0] ramData;
        logic        ramWrite;
        logic        bootDone;
        logic        bootError;
        logic [7:0]  checksum;
    } snap_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic        resetA, romDoneA, ramWriteA, ramReadyA, bootDoneA, bootErrorA;
    logic [31:0] romAddressA, ramAddressA, ramDataA;
    logic [7:0]  romByteA;
    logic        resetB, romDoneB, ramWriteB, ramReadyB, bootDoneB, bootErrorB;
    logic [31:0] romAddressB, ramAddressB, ramDataB;
    logic [7:0]  romByteB;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  checksumA, checksumB;
`endif

    logic [7:0]  imgA [0:511];
    logic [7:0]  imgB [0:511];
    int          doneIdxA = -1;
    int          doneIdxB = -1;
    bit          randReadyA = 1'b0;

    logic [63:0] gotA [$];
    logic [63:0] gotB [$];
    logic [63:0] expQ [$];

    // Combinational ROM models
    assign romByteA = imgA[romAddressA[8:0]];
    assign romDoneA = (doneIdxA >= 0) && (romAddressA == 32'(doneIdxA));
    assign romByteB = imgB[romAddressB[8:0]];
    assign romDoneB = (doneIdxB >= 0) && (romAddressB == 32'(doneIdxB));

    rom_loader #(.RAM_BASE(BASE_A), .MAX_BYTES(MAX_A)) dutA (
        .clock(clock), .reset(resetA),
        .rom_address(romAddressA), .rom_byte(romByteA), .rom_done(romDoneA),
        .ram_address(ramAddressA), .ram_data(ramDataA), .ram_write(ramWriteA),
        .ram_ready(ramReadyA), .boot_done(bootDoneA), .boot_error(bootErrorA)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .checksum(checksumA)
`endif
    );

    rom_loader #(.RAM_BASE(BASE_B), .MAX_BYTES(MAX_B)) dutB (
        .clock(clock), .reset(resetB),
        .rom_address(romAddressB), .rom_byte(romByteB), .rom_done(romDoneB),
        .ram_address(ramAddressB), .ram_data(ramDataB), .ram_write(ramWriteB),
        .ram_ready(ramReadyB), .boot_done(bootDoneB), .boot_error(bootErrorB)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .checksum(checksumB)
`endif
    );

    // Record every write that the next rising edge will accept.
    always @(negedge clock) begin
        if (!resetA && ramWriteA && ramReadyA) gotA.push_back({ramAddressA, ramDataA});
        if (!resetB && ramWriteB && ramReadyB) gotB.push_back({ramAddressB, ramDataB});
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
        if (randReadyA) ramReadyA = ($urandom_range(0, 3) != 0);
    endtask

    function automatic snap_t snap(input int which);
        snap_t s;
        s = '0;
        if (which == 0) begin
            s.romAddress = romAddressA; s.ramAddress = ramAddressA; s.ramData = ramDataA;
            s.ramWrite = ramWriteA; s.bootDone = bootDoneA; s.bootError = bootErrorA;
`ifdef ROM_LOADER_CHECKSUM_EN
            s.checksum = checksumA;
`endif
        end else begin
            s.romAddress = romAddressB; s.ramAddress = ramAddressB; s.ramData = ramDataB;
            s.ramWrite = ramWriteB; s.bootDone = bootDoneB; s.bootError = bootErrorB;
`ifdef ROM_LOADER_CHECKSUM_EN
            s.checksum = checksumB;
`endif
        end
        return s;
    endfunction

    function automatic logic [7:0] imgByte(input int which, input int idx);
        return (which == 0) ? imgA[idx] : imgB[idx];
    endfunction

    task automatic fillRandom(input int which);
        for (int i = 0; i < 512; i++) begin
            if (which == 0) imgA[i] = 8'($urandom);
            else            imgB[i] = 8'($urandom);
        end
    endtask

    // Reset for two edges, check the reset state, then release.
    task automatic applyStimulus(input int which, input bit randomReady);
        snap_t s;
        if (which == 0) begin
            gotA.delete(); randReadyA = randomReady; ramReadyA = 1'b1; resetA = 1'b1;
        end else begin
            gotB.delete(); ramReadyB = 1'b1; resetB = 1'b1;
        end
        stepCycle();
        stepCycle();
        s = snap(which);
        checkOutput("reset.rom_address", 64'(s.romAddress), 64'd0);
        checkOutput("reset.ram_address", 64'(s.ramAddress), 64'((which == 0) ? BASE_A : BASE_B));
        checkOutput("reset.ram_data", 64'(s.ramData), 64'd0);
        checkOutput("reset.ram_write", 64'(s.ramWrite), 64'd0);
        checkOutput("reset.boot_done", 64'(s.bootDone), 64'd0);
        checkOutput("reset.boot_error", 64'(s.bootError), 64'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
        checkOutput("reset.checksum", 64'(s.checksum), 64'd0);
`endif
        if (which == 0) resetA = 1'b0;
        else            resetB = 1'b0;
    endtask

    // Run until boot_done/boot_error; cycles counts edges after release.
    task automatic waitLoad(input int which, input string name, output int cycles);
        bit    finished;
        snap_t s;
        finished = 1'b0;
        cycles = 0;
        while (!finished && cycles < BUDGET) begin
            stepCycle();
            cycles++;
            s = snap(which);
            if (s.bootDone || s.bootError) finished = 1'b1;
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.timeout: no boot_done/boot_error after %0d cycles, required within %0d", name, cycles, BUDGET);
        end
        repeat (6) stepCycle();
    endtask

    // Reference model: which bytes get written, where, and how the load ends.
    task automatic checkRun(input int which, input string name, input int maxBytes, input logic [31:0] base);
        int          nBytes;
        bit          endsDone;
        logic [31:0] word;
        logic [7:0]  sum;
        logic [63:0] got [$];
        snap_t       s;
        int          doneIdx;
        doneIdx = (which == 0) ? doneIdxA : doneIdxB;
        if (doneIdx >= 0 && doneIdx < maxBytes) begin
            endsDone = 1'b1; nBytes = doneIdx + 1;
        end else begin
            endsDone = 1'b0; nBytes = (maxBytes / 4) * 4;
        end
        expQ.delete();
        for (int w = 0; w * 4 < nBytes; w++) begin
            word = '0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < nBytes) word[31 - 8 * k -: 8] = imgByte(which, w * 4 + k);
            expQ.push_back({base + 32'(w), word});
        end
        sum = '0;
        for (int i = 0; i < (endsDone ? nBytes : maxBytes); i++) sum = sum + imgByte(which, i);
        if (which == 0) got = gotA;
        else            got = gotB;
        checkOutput({name, ".writes"}, 64'(got.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < got.size(); i++)
            checkOutput($sformatf("%s.write%0d", name, i), got[i], expQ[i]);
        s = snap(which);
        checkOutput({name, ".boot_done"}, 64'(s.bootDone), 64'(endsDone));
        checkOutput({name, ".boot_error"}, 64'(s.bootError), 64'(!endsDone));
        checkOutput({name, ".ram_write_idle"}, 64'(s.ramWrite), 64'd0);
        checkOutput({name, ".rom_address"}, 64'(s.romAddress), 64'(endsDone ? nBytes : maxBytes));
`ifdef ROM_LOADER_CHECKSUM_EN
        checkOutput({name, ".checksum"}, 64'(s.checksum), 64'(sum));
`else
        if (sum == 8'h00) begin
        end
`endif
    endtask

    initial begin
        vector_t     vectors [8];
        int          cycles;
        snap_t       s;
        logic [63:0] firstWord;
        logic [31:0] stallWord;
        string       name;

        resetA = 1'b1; resetB = 1'b1; ramReadyA = 1'b1; ramReadyB = 1'b1;
        fillRandom(0);
        fillRandom(1);

        vectors[0] = '{len:8,   hasDone:1, randomReady:0, expWrites:2,  expBootDone:1, expCycles:10};
        vectors[1] = '{len:6,   hasDone:1, randomReady:0, expWrites:2,  expBootDone:1, expCycles:8};
        vectors[2] = '{len:1,   hasDone:1, randomReady:0, expWrites:1,  expBootDone:1, expCycles:2};
        vectors[3] = '{len:5,   hasDone:1, randomReady:0, expWrites:2,  expBootDone:1, expCycles:7};
        vectors[4] = '{len:292, hasDone:1, randomReady:0, expWrites:73, expBootDone:1, expCycles:365};
        vectors[5] = '{len:302, hasDone:1, randomReady:0, expWrites:76, expBootDone:1, expCycles:378};
        vectors[6] = '{len:302, hasDone:0, randomReady:0, expWrites:75, expBootDone:0, expCycles:378};
        vectors[7] = '{len:13,  hasDone:1, randomReady:1, expWrites:4,  expBootDone:1, expCycles:-1};

        for (int v = 0; v < 8; v++) begin
            name = $sformatf("vec%0d", v);
            fillRandom(0);
            doneIdxA = vectors[v].hasDone ? vectors[v].len - 1 : -1;
            applyStimulus(0, vectors[v].randomReady);
            waitLoad(0, name, cycles);
            checkRun(0, name, int'(MAX_A), BASE_A);
            checkOutput({name, ".count"}, 64'(gotA.size()), 64'(vectors[v].expWrites));
            checkOutput({name, ".done"}, 64'(bootDoneA), 64'(vectors[v].expBootDone));
            if (vectors[v].expCycles >= 0)
                checkOutput({name, ".cycles"}, 64'(cycles), 64'(vectors[v].expCycles));
        end

        // Two-word image with known contents
        for (int i = 0; i < 8; i++) imgA[i] = 8'h00;
        imgA[3] = 8'h01; imgA[7] = 8'h0E; doneIdxA = 7;
        applyStimulus(0, 1'b0);
        waitLoad(0, "twoword", cycles);
        checkOutput("twoword.cycles", 64'(cycles), 64'd10);
        checkOutput("twoword.count", 64'(gotA.size()), 64'd2);
        if (gotA.size() >= 2) begin
            checkOutput("twoword.w0", gotA[0], {32'h0, 32'h0000_0001});
            checkOutput("twoword.w1", gotA[1], {32'h1, 32'h0000_000E});
        end

        // Partial final word
        imgA[0] = 8'h11; imgA[1] = 8'h22; imgA[2] = 8'h33; imgA[3] = 8'h44;
        imgA[4] = 8'hAA; imgA[5] = 8'hBB; doneIdxA = 5;
        applyStimulus(0, 1'b0);
        waitLoad(0, "partial", cycles);
        checkOutput("partial.done", 64'(bootDoneA), 64'd1);
        if (gotA.size() >= 2) checkOutput("partial.w1", gotA[1], {32'h1, 32'hAABB_0000});
        else checkOutput("partial.count", 64'(gotA.size()), 64'd2);

        // RAM stalls for three cycles on the first write
        fillRandom(0);
        doneIdxA = 11;
        applyStimulus(0, 1'b0);
        ramReadyA = 1'b0;
        repeat (4) stepCycle();
        stallWord = {imgA[0], imgA[1], imgA[2], imgA[3]};
        for (int c = 0; c < 4; c++) begin
            s = snap(0);
            checkOutput($sformatf("stall%0d.ram_write", c), 64'(s.ramWrite), 64'd1);
            checkOutput($sformatf("stall%0d.ram_data", c), 64'(s.ramData), 64'(stallWord));
            checkOutput($sformatf("stall%0d.ram_address", c), 64'(s.ramAddress), 64'(BASE_A));
            checkOutput($sformatf("stall%0d.rom_address", c), 64'(s.romAddress), 64'd4);
            if (c < 3) stepCycle();
        end
        ramReadyA = 1'b1;
        stepCycle();
        s = snap(0);
        checkOutput("stall.release.ram_write", 64'(s.ramWrite), 64'd0);
        checkOutput("stall.release.ram_address", 64'(s.ramAddress), 64'(BASE_A + 32'd1));
        waitLoad(0, "stall", cycles);
        checkRun(0, "stall", int'(MAX_A), BASE_A);

        // Reset during the second write, then a clean rerun
        fillRandom(0);
        doneIdxA = 15;
        applyStimulus(0, 1'b0);
        repeat (9) stepCycle();
        checkOutput("abort.in_write", 64'(ramWriteA), 64'd1);
        firstWord = (gotA.size() > 0) ? gotA[0] : 64'd0;
        resetA = 1'b1;
        stepCycle();
        s = snap(0);
        checkOutput("abort.ram_write", 64'(s.ramWrite), 64'd0);
        checkOutput("abort.rom_address", 64'(s.romAddress), 64'd0);
        checkOutput("abort.ram_address", 64'(s.ramAddress), 64'(BASE_A));
        resetA = 1'b0;
        gotA.delete();
        waitLoad(0, "rerun", cycles);
        checkRun(0, "rerun", int'(MAX_A), BASE_A);
        if (gotA.size() > 0) checkOutput("rerun.word0", gotA[0], firstWord);

        // Overrun on instance B: two full words, then error
        fillRandom(1);
        doneIdxB = -1;
        applyStimulus(1, 1'b0);
        waitLoad(1, "overrun", cycles);
        checkRun(1, "overrun", int'(MAX_B), BASE_B);
        checkOutput("overrun.count", 64'(gotB.size()), 64'd2);
        checkOutput("overrun.cycles", 64'(cycles), 64'd11);
        resetB = 1'b1;

`ifdef ROM_LOADER_CHECKSUM_EN
        imgA[0] = 8'h80; imgA[1] = 8'h80; imgA[2] = 8'h01; imgA[3] = 8'h02; doneIdxA = 3;
        applyStimulus(0, 1'b0);
        waitLoad(0, "csum", cycles);
        checkOutput("csum.value", 64'(checksumA), 64'h03);
`endif

        // Randomized images and RAM back-pressure
        for (int r = 0; r < 20; r++) begin
            name = $sformatf("rand%0d", r);
            fillRandom(0);
            doneIdxA = (r % 7 == 6) ? -1 : $urandom_range(0, 39);
            applyStimulus(0, 1'b1);
            waitLoad(0, name, cycles);
            checkRun(0, name, int'(MAX_A), BASE_A);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'd0, RAM word address receiving the first assembled word.
REQ-002 SHALL have parameter MAX_BYTES, default 32'd65536, byte-count limit before declaring overrun.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; one clock, synchronous, active-high reset.
REQ-005 SHALL have port rom_address, output, 32, registered byte address driven to the ROM.
REQ-006 SHALL have port rom_byte, input, 8, combinational ROM data for rom_address, valid in the same cycle.
REQ-007 SHALL have port rom_done, input, 1, high when rom_address is the last image byte.
REQ-008 SHALL have port ram_address, output, 32, word address of the pending write.
REQ-009 SHALL have port ram_data, output, 32, assembled word.
REQ-010 SHALL have port ram_write, output, 1, write request.
REQ-011 SHALL have port ram_ready, input, 1, RAM accepts the write in any cycle where ram_write and ram_ready are both high.
REQ-012 SHALL have port boot_done, output, 1, image fully written; CPU may leave reset.
REQ-013 SHALL have port boot_error, output, 1, MAX_BYTES reached without rom_done.

Function
REQ-014 SHALL use the states FETCH, WRITE, DONE and ERROR; FETCH is entered on reset.
REQ-015 In FETCH, each cycle SHALL shift rom_byte into the word register (first byte = bits 31:24, big-endian), increment rom_address and the byte-lane count, and check rom_done.
REQ-016 On the 4th lane or on rom_done, SHALL move to WRITE; a partial word is left-aligned and zero-padded in its low bytes.
REQ-017 In WRITE, SHALL hold ram_write, ram_address and ram_data stable until ram_ready; ram_write deasserts the cycle after acceptance.
REQ-018 After acceptance, SHALL increment ram_address by 1 and go to DONE if the written word contained the rom_done byte, else to FETCH.
REQ-019 In FETCH, rom_address SHALL freeze while WRITE is pending; no byte is sampled outside FETCH.
REQ-020 In DONE, boot_done SHALL be 1 and sticky; ram_write stays 0 and rom_address holds.
REQ-021 If the byte count reaches MAX_BYTES in FETCH without rom_done, SHALL enter ERROR: boot_error=1 (sticky), no further writes, and any partial word is discarded.
REQ-022 If rom_done and the MAX_BYTES limit coincide on the same byte, rom_done SHALL take priority and the load completes normally.
REQ-023 Throughput SHALL be 4 FETCH cycles plus at least 1 WRITE cycle per word; with ram_ready tied high, a 292-byte image completes in 73*5 = 365 cycles after reset release.

Reset
REQ-024 Reset SHALL give: rom_address=0, ram_address=RAM_BASE, ram_data=0, ram_write=0, boot_done=0, boot_error=0, lane count=0, state=FETCH.
REQ-025 Reset asserted mid-operation, including in WRITE with ram_write high, SHALL abort the load immediately and restart from byte 0 on release.

Configuration
REQ-026 With macro ROM_LOADER_CHECKSUM_EN defined, SHALL add output checksum[7:0]: modulo-256 sum of every sampled byte, reset to 0, frozen in DONE/ERROR.
REQ-027 Without ROM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-028 Package rom_loader_pkg SHALL hold the state enum (FETCH, WRITE, DONE, ERROR) and the constant BYTES_PER_WORD=4.
REQ-029 One sub-module, rom_loader_packer, SHALL hold the byte shift, lane count and zero-pad logic; the FSM stays in rom_loader.

Verification
REQ-030 8-byte image 00 00 00 01 00 00 00 0E, ram_ready=1 -> writes 0x00000001@0 and 0x0000000E@1; boot_done high at cycle 10.
REQ-031 6-byte image ending in 0xAA,0xBB -> second write is 0xAABB0000; boot_done=1.
REQ-032 ram_ready held low 3 cycles in WRITE -> ram_write/ram_data stable for 4 cycles, rom_address unchanged, exactly one write accepted.
REQ-033 rom_done never asserted, MAX_BYTES=8 -> exactly 2 writes, then boot_error=1 and no further ram_write.
REQ-034 Reset pulsed in the 2nd WRITE -> ram_write=0 next cycle; rerun writes from RAM_BASE with identical data.
REQ-035 With ROM_LOADER_CHECKSUM_EN, bytes 0x80,0x80,0x01,0x02 (rom_done on last) -> checksum=0x03.
